// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Borrow_in, LSB first, one bit per clock
// behind valid/ready operand and result handshakes.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow_out,
    output logic             Overflow,
    output logic             Zero
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic             bit_d, br_nx, last;
    logic [WIDTH-1:0] r_nx;
    assign bit_d = a_q[0] ^ b_q[0] ^ br_q;
    assign br_nx = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign r_nx  = {bit_d, r_q[WIDTH-1:1]};
    assign last  = cnt_q == CW'(WIDTH - 1);
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = A;
                b_d     = B;
                br_d    = Borrow_in;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = r_nx;
                br_d  = br_nx;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    // br_q here is the borrow into the MSB, so overflow is its mismatch with the borrow out
                    bout_d  = br_nx;
                    ovf_d   = br_q ^ br_nx;
                    zero_d  = r_nx == '0;
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end
    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q == DONE;
    assign Diff       = r_q;
    assign Borrow_out = bout_q;
    assign Overflow   = ovf_q;
    assign Zero       = zero_q;
endmodule
